// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - Paces the HPS ioctl download stream into SDRAM boot-port byte writes.
module rom_loader #(
    parameter int         SYS_PAGES = 8,
    parameter logic [8:0] MF2_PAGE  = 9'h1FF,
    parameter logic [8:0] BAD_PAGE  = 9'h1EE
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         ce_ref,
    input  logic         ioctl_download,
    input  logic         ioctl_wr,
    input  logic [24:0]  ioctl_addr,
    input  logic [7:0]   ioctl_dout,
    input  logic [7:0]   ioctl_index,
    input  logic [31:0]  ioctl_file_ext,
    output logic         ioctl_wait,
    output logic         boot_wr,
    output logic [22:0]  boot_a,
    output logic [1:0]   boot_bank,
    output logic [7:0]   boot_dout,
    output logic [255:0] rom_map
);

    typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

    state_t      state;
    logic [1:0]  rst_sync;
    logic        rst_n;
    logic        dl_q;
    logic [8:0]  page;
    logic        combo;
    logic        page_skip;
    logic        dual;
    logic [8:0]  start_page;
    logic        start_combo;
    logic [4:0]  nib_hi;
    logic [4:0]  nib_lo;
    logic [10:0] slot;
    logic [8:0]  sys_page;
    logic        sys_drop;
    logic [7:0]  ext_page_lo;
    logic        unused_ext;

    assign unused_ext = ^ioctl_file_ext[31:16];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Returns {valid, value} for an ASCII hex digit 0-9 / A-F.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
        else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
        else                               return 5'd0;
    endfunction

    always_comb begin
        start_page  = BAD_PAGE;
        start_combo = 1'b0;
        nib_hi      = hex_nib(ioctl_file_ext[15:8]);
        nib_lo      = hex_nib(ioctl_file_ext[7:0]);
        if (nib_hi[4]) start_page[7:4] = nib_hi[3:0];
        if (nib_lo[4]) start_page[3:0] = nib_lo[3:0];
        if (ioctl_file_ext[15:0] == 16'h5A5A) begin
            start_page = 9'h000;
        end else if (ioctl_file_ext[15:0] == 16'h5A30) begin
            start_page  = 9'h000;
            start_combo = 1'b1;
        end
    end

    assign slot     = ioctl_addr[24:14];
    assign sys_drop = int'(slot) >= SYS_PAGES;

    always_comb begin
        case (slot[1:0])
            2'd0:    sys_page = 9'h000;
            2'd1:    sys_page = 9'h100;
            2'd2:    sys_page = 9'h107;
            default: sys_page = MF2_PAGE;
        endcase
    end

    // The MF2 half of a combo file starts at file page 1; page_skip rebases it onto MF2_PAGE.
    assign ext_page_lo = page[7:0] + ioctl_addr[21:14] - {7'd0, page_skip};

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            page       <= 9'h000;
            combo      <= 1'b0;
            page_skip  <= 1'b0;
            dual       <= 1'b0;
            ioctl_wait <= 1'b0;
            boot_wr    <= 1'b0;
            boot_a     <= '0;
            boot_bank  <= 2'd0;
            boot_dout  <= 8'd0;
            rom_map    <= '0;
        end else begin
            dl_q <= ioctl_download;
            if (ioctl_download && !dl_q && ioctl_index != 8'd0) begin
                page      <= start_page;
                combo     <= start_combo;
                page_skip <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ioctl_download && ioctl_wr) begin
                        if (ioctl_index == 8'd0) begin
                            if (!sys_drop) begin
                                boot_dout  <= ioctl_dout;
                                boot_a     <= {sys_page, ioctl_addr[13:0]};
                                boot_bank  <= {1'b0, slot >= 11'd4};
                                dual       <= 1'b0;
                                ioctl_wait <= 1'b1;
                                state      <= ARM;
                            end
                        end else begin
                            boot_dout  <= ioctl_dout;
                            boot_a     <= {page[8], ext_page_lo, ioctl_addr[13:0]};
                            boot_bank  <= {1'b0, &ioctl_index[7:6]};
                            dual       <= (ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0);
                            ioctl_wait <= 1'b1;
                            state      <= ARM;
                        end
                    end
                end
                ARM: begin
                    if (ce_ref) begin
                        boot_wr <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (ce_ref) begin
                        boot_wr <= 1'b0;
                        if (boot_a[22]) rom_map[boot_a[21:14]] <= 1'b1;
                        if (dual && boot_bank == 2'd0) begin
                            boot_bank <= 2'd1;
                            state     <= ARM;
                        end else begin
                            ioctl_wait <= 1'b0;
                            state      <= IDLE;
                        end
                        if (combo && &boot_a[13:0]) begin
                            page      <= MF2_PAGE;
                            combo     <= 1'b0;
                            page_skip <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - Scoreboard bench for rom_loader.
module tb_rom_loader;

    logic         clk_sys = 1'b0;
    logic         reset_n;
    logic         ce_ref;
    logic         ioctl_download;
    logic         ioctl_wr;
    logic [24:0]  ioctl_addr;
    logic [7:0]   ioctl_dout;
    logic [7:0]   ioctl_index;
    logic [31:0]  ioctl_file_ext;
    logic         ioctl_wait;
    logic         boot_wr;
    logic [22:0]  boot_a;
    logic [1:0]   boot_bank;
    logic [7:0]   boot_dout;
    logic [255:0] rom_map;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  bank;
        logic [7:0]  d;
    } wr_t;

    wr_t          exp_q[$];
    int           checks = 0;
    int           failures = 0;
    logic [255:0] exp_map = '0;
    logic         wr_prev = 1'b0;
    int           hi_len = 0;
    int           ces;
    logic [7:0]   ce_cnt = 8'd0;

    rom_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_ref(ce_ref),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_file_ext(ioctl_file_ext),
        .ioctl_wait(ioctl_wait), .boot_wr(boot_wr), .boot_a(boot_a), .boot_bank(boot_bank),
        .boot_dout(boot_dout), .rom_map(rom_map)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        ce_ref = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            ce_cnt = ce_cnt + 8'd1;
            ce_ref = (ce_cnt[3:0] == 4'd0);
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every boot write against the scoreboard and checks its width.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                wr_prev = 1'b0;
                hi_len  = 0;
            end else begin
                if (boot_wr) begin
                    if (!wr_prev) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_boot_wr", {233'd0, boot_a}, 256'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("boot_a", {233'd0, boot_a}, {233'd0, e.a});
                            chk("boot_bank", {254'd0, boot_bank}, {254'd0, e.bank});
                            chk("boot_dout", {248'd0, boot_dout}, {248'd0, e.d});
                        end
                    end
                    hi_len++;
                end else if (wr_prev) begin
                    chk("boot_wr_len", 256'(hi_len), 256'd16);
                    hi_len = 0;
                end
                wr_prev = boot_wr;
            end
        end
    end

    task automatic start_dl(input logic [7:0] idx, input logic [31:0] ext);
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        ioctl_index    = idx;
        ioctl_file_ext = ext;
        repeat (2) @(posedge clk_sys);
        #1 ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic push(input logic [8:0] pg, input logic [13:0] off, input logic [1:0] bank, input logic [7:0] d);
        exp_q.push_back({pg, off, bank, d});
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        @(posedge clk_sys); #1;
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (ioctl_wait && ce_ref) n++;
            if (!ioctl_wait) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("ioctl_wait_timeout", 256'd1, 256'd0);
    endtask

    initial begin
        int seen;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        ioctl_file_ext = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_boot_wr", {255'd0, boot_wr}, 256'd0);
        chk("rst_ioctl_wait", {255'd0, ioctl_wait}, 256'd0);
        chk("rst_boot_a", {233'd0, boot_a}, 256'd0);
        chk("rst_boot_bank", {254'd0, boot_bank}, 256'd0);
        chk("rst_boot_dout", {248'd0, boot_dout}, 256'd0);
        chk("rst_rom_map", rom_map, 256'd0);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);

        // Combo "Z0": first page to 000 in both banks, second page rebased onto MF2_PAGE.
        start_dl(8'd1, 32'h0000_5A30);
        push(9'h000, 14'h0000, 2'd0, 8'hA0); push(9'h000, 14'h0000, 2'd1, 8'hA0);
        send_byte(25'h0000, 8'hA0, ces); chk("combo_b0_ces", 256'(ces), 256'd4);
        push(9'h000, 14'h3FFF, 2'd0, 8'hA1); push(9'h000, 14'h3FFF, 2'd1, 8'hA1);
        send_byte(25'h3FFF, 8'hA1, ces); chk("combo_3fff_ces", 256'(ces), 256'd4);
        push(9'h1FF, 14'h0000, 2'd0, 8'hA2); push(9'h1FF, 14'h0000, 2'd1, 8'hA2);
        send_byte(25'h4000, 8'hA2, ces); chk("combo_4000_ces", 256'(ces), 256'd4);
        exp_map[8'hFF] = 1'b1;
        chk("combo_rom_map", rom_map, exp_map);

        // System ROM, slot 1 -> page 100, single write.
        start_dl(8'd0, 32'h0);
        push(9'h100, 14'h0010, 2'd0, 8'h5A);
        send_byte(25'h04010, 8'h5A, ces); chk("sys_ces", 256'(ces), 256'd2);
        exp_map[8'h00] = 1'b1;
        chk("sys_rom_map", rom_map, exp_map);

        // System ROM, slot 8 -> dropped.
        send_byte(25'h20000, 8'h77, ces); chk("sys_drop_ces", 256'(ces), 256'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (ioctl_wait) seen++;
        end
        chk("sys_drop_wait", 256'(seen), 256'd0);

        // "e3A" -> page 13A, dual bank.
        start_dl(8'd1, 32'h0065_3341);
        push(9'h13A, 14'h0123, 2'd0, 8'hC3); push(9'h13A, 14'h0123, 2'd1, 8'hC3);
        send_byte(25'h0123, 8'hC3, ces); chk("e3A_ces", 256'(ces), 256'd4);
        exp_map[8'h3A] = 1'b1;

        // "eQ7" -> page 1E7; "eQQ" -> page 1EE.
        start_dl(8'd1, 32'h0065_5137);
        push(9'h1E7, 14'h0000, 2'd0, 8'h11); push(9'h1E7, 14'h0000, 2'd1, 8'h11);
        send_byte(25'h0000, 8'h11, ces); chk("eQ7_ces", 256'(ces), 256'd4);
        exp_map[8'hE7] = 1'b1;
        start_dl(8'd1, 32'h0065_5151);
        push(9'h1EE, 14'h0010, 2'd0, 8'h22); push(9'h1EE, 14'h0010, 2'd1, 8'h22);
        send_byte(25'h0010, 8'h22, ces); chk("eQQ_ces", 256'(ces), 256'd4);
        exp_map[8'hEE] = 1'b1;

        // Index C0 ("e05"): bank 1 only, file page 1 -> page 106.
        start_dl(8'hC0, 32'h0065_3035);
        push(9'h106, 14'h0002, 2'd1, 8'h33);
        send_byte(25'h4002, 8'h33, ces); chk("idxC0_ces", 256'(ces), 256'd2);
        exp_map[8'h06] = 1'b1;
        chk("rom_map_accum", rom_map, exp_map);
        chk("queue_empty", 256'(exp_q.size()), 256'd0);

        // Reset while in WRITE.
        start_dl(8'd1, 32'h0065_3341);
        push(9'h13A, 14'h0001, 2'd0, 8'h44);
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h0001; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
        @(posedge clk_sys); #1 ioctl_wr = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (boot_wr) begin
                seen = 1;
                break;
            end
        end
        chk("reset_test_wr_seen", 256'(seen), 256'd1);
        repeat (3) @(negedge clk_sys);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_boot_wr", {255'd0, boot_wr}, 256'd0);
        chk("midrst_ioctl_wait", {255'd0, ioctl_wait}, 256'd0);
        chk("midrst_rom_map", rom_map, 256'd0);
        repeat (3) @(posedge clk_sys);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
